calc_input_fsm: RTL and testbench



---
 rtl/calc_input_fsm.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_calc_input_fsm.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_input_fsm.sv
// -----------------------------------------------------------------------------
// calc_input_fsm
//
// Entry controller sitting between keypad_driver and the calculate /
// segment_driver pair. It turns held-level key codes into single press events,
// assembles two signed decimal operands and an operator, fires the
// calculation, latches the result as ANS and drives the display word.
//
// Optional feature macro: CALC_BACKSPACE_EN
//   defined   : BKSP (5'h1D) edits the operand being entered in S_OP1 / S_OP2
//   undefined : 5'h1D is an unused code and no divide-by-10 logic exists
//
// Ports
//   sw_clk      in   1  system clock (shared with keypad_driver / calculate)
//   rst         in   1  asynchronous, active-high reset
//   eBCD        in   5  held-level key code, KEY_IDLE when no key is pressed
//   ans         in  32  signed result from calculate, 32'h00EE_0000 = error
//   operand1    out 32  signed first operand
//   operand2    out 32  signed second operand
//   operator    out  3  1 *, 2 /, 3 +, 4 -, 5 %
//   calc_go     out  1  one-cycle pulse when EQUAL is accepted
//   fnd_serial  out 32  display word for segment_driver
//   o_dbg_state out  3  current FSM state (S_OP1=0 ... S_ERROR=5)
//
// Calculation contract: calc_go is a single-cycle strobe with no back
// pressure. operand1/operand2/operator are stable from the strobe onward,
// and ans is sampled exactly RESULT_LAT cycles after the strobe edge.
// -----------------------------------------------------------------------------
module calc_input_fsm #(
  parameter int         MAX_DIGITS = 6,
  parameter int         RESULT_LAT = 2,
  parameter logic [4:0] KEY_IDLE   = 5'h1F
) (
  input  logic        sw_clk,
  input  logic        rst,
  input  logic [4:0]  eBCD,
  input  logic [31:0] ans,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [2:0]  operator,
  output logic        calc_go,
  output logic [31:0] fnd_serial,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_OP1    = 3'd0,
    S_OPR    = 3'd1,
    S_OP2    = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [3:0]  LIM_POS   = 4'(MAX_DIGITS);
  localparam logic [3:0]  LIM_NEG   = 4'(MAX_DIGITS - 1);
  localparam logic [7:0]  WAIT_LAST = 8'(RESULT_LAT - 1);
  localparam logic [31:0] ANS_ERROR = 32'h00EE_0000;
  localparam logic [31:0] DISP_ANS  = 32'h00B0_0000;
  localparam logic [31:0] DISP_NANS = 32'hE0B0_0000;
  localparam logic [31:0] DISP_NEG0 = 32'hE000_0000;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [4:0]  r_prev_key;
  logic        r_evt_valid;
  logic [4:0]  r_evt_key;
  logic [31:0] r_mag;
  logic [3:0]  r_cnt;
  logic        r_neg;
  logic        r_ans_tok;
  logic [31:0] r_ans_reg;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_operand1;
  logic [31:0] r_operand2;
  logic [2:0]  r_operator;
  logic        r_calc_go;
  logic [31:0] r_fnd;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t      w_state_n;
  logic [31:0] w_mag_n;
  logic [3:0]  w_cnt_n;
  logic        w_neg_n;
  logic        w_tok_n;
  logic [31:0] w_ans_reg_n;
  logic [7:0]  w_wait_n;
  logic [31:0] w_op1_n;
  logic [31:0] w_op2_n;
  logic [2:0]  w_opr_n;
  logic        w_go_n;
  logic [31:0] w_fnd_n;

  // Entry-edit controls and the entry the edit starts from
  logic        w_apply;
  logic        w_clear;
  logic [31:0] w_base_mag;
  logic [3:0]  w_base_cnt;
  logic        w_base_neg;
  logic        w_base_tok;
  logic [3:0]  w_limit;

  // ---------------------------------------------------------------------------
  // Key decode of the registered press event
  // ---------------------------------------------------------------------------
  logic        w_edge;
  logic        w_is_digit;
  logic        w_is_opr;
  logic        w_is_eq;
  logic        w_is_ans;
  logic        w_is_sign;
  logic        w_is_entry;
  logic [31:0] w_digit;
  logic [31:0] w_value;

  // A press is the first non-idle cycle after idle; sliding from one code to
  // another without releasing produces nothing.
  assign w_edge     = (eBCD != KEY_IDLE) && (r_prev_key == KEY_IDLE);

  assign w_is_digit = r_evt_valid && (r_evt_key <= 5'h09);
  assign w_is_opr   = r_evt_valid && (r_evt_key >= 5'h11) && (r_evt_key <= 5'h15);
  assign w_is_eq    = r_evt_valid && (r_evt_key == 5'h1A);
  assign w_is_ans   = r_evt_valid && (r_evt_key == 5'h1B);
  assign w_is_sign  = r_evt_valid && (r_evt_key == 5'h1C);
  assign w_is_entry = w_is_digit || w_is_ans || w_is_sign;
  assign w_digit    = {28'd0, r_evt_key[3:0]};

`ifdef CALC_BACKSPACE_EN
  logic w_is_bksp;
  assign w_is_bksp  = r_evt_valid && (r_evt_key == 5'h1D);
`endif

  // Signed value of the operand currently being entered
  assign w_value = r_ans_tok ? (r_neg ? (32'd0 - r_ans_reg) : r_ans_reg)
                             : (r_neg ? (32'd0 - r_mag)     : r_mag);

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_n   = r_state;
    w_mag_n     = r_mag;
    w_cnt_n     = r_cnt;
    w_neg_n     = r_neg;
    w_tok_n     = r_ans_tok;
    w_ans_reg_n = r_ans_reg;
    w_wait_n    = r_wait_cnt;
    w_op1_n     = r_operand1;
    w_op2_n     = r_operand2;
    w_opr_n     = r_operator;
    w_go_n      = 1'b0;
    w_apply     = 1'b0;
    w_clear     = 1'b0;
    w_base_mag  = r_mag;
    w_base_cnt  = r_cnt;
    w_base_neg  = r_neg;
    w_base_tok  = r_ans_tok;
    w_limit     = LIM_POS;

    unique case (r_state)
      S_OP1: begin
        if (w_is_opr) begin
          w_op1_n   = w_value;
          w_opr_n   = r_evt_key[2:0];
          w_state_n = S_OPR;
        end else begin
          // EQUAL and unused codes fall through the entry editor untouched
          w_apply = 1'b1;
        end
      end

      S_OPR: begin
        if (w_is_opr) begin
          w_opr_n = r_evt_key[2:0];
        end else if (w_is_entry) begin
          w_clear   = 1'b1;
          w_apply   = 1'b1;
          w_state_n = S_OP2;
        end
      end

      S_OP2: begin
        if (w_is_eq) begin
          w_op2_n   = w_value;
          w_go_n    = 1'b1;
          w_wait_n  = 8'd0;
          w_state_n = S_WAIT;
        end else if (!w_is_opr) begin
          w_apply = 1'b1;
        end
      end

      S_WAIT: begin
        // Presses arriving here are dropped; the event register still runs.
        if (r_wait_cnt == WAIT_LAST) begin
          if (ans == ANS_ERROR) begin
            w_state_n = S_ERROR;
          end else begin
            w_ans_reg_n = ans;
            w_state_n   = S_RESULT;
          end
        end else begin
          w_wait_n = r_wait_cnt + 8'd1;
        end
      end

      S_RESULT: begin
        if (w_is_opr) begin
          w_op1_n   = r_ans_reg;
          w_opr_n   = r_evt_key[2:0];
          w_state_n = S_OPR;
        end else if (w_is_entry) begin
          w_clear   = 1'b1;
          w_apply   = 1'b1;
          w_state_n = S_OP1;
        end
      end

      S_ERROR: begin
        if (w_is_digit) begin
          w_clear   = 1'b1;
          w_apply   = 1'b1;
          w_state_n = S_OP1;
        end
      end

      default: begin
        w_state_n = S_OP1;
      end
    endcase

    // Entry editor: starts from either the live entry or an empty one so that
    // the key that opens a new operand is applied in the same cycle.
    if (w_clear) begin
      w_base_mag = 32'd0;
      w_base_cnt = 4'd0;
      w_base_neg = 1'b0;
      w_base_tok = 1'b0;
    end
    w_limit = w_base_neg ? LIM_NEG : LIM_POS;

    if (w_apply) begin
      w_mag_n = w_base_mag;
      w_cnt_n = w_base_cnt;
      w_neg_n = w_base_neg;
      w_tok_n = w_base_tok;
      if (w_is_digit) begin
        // Leading zeros do not consume a digit slot
        if (!w_base_tok && (w_base_cnt < w_limit) &&
            !((w_base_mag == 32'd0) && (w_digit == 32'd0))) begin
          w_mag_n = (w_base_mag * 32'd10) + w_digit;
          w_cnt_n = w_base_cnt + 4'd1;
        end
      end else if (w_is_sign) begin
        // A full positive entry has no room for the minus sign
        if (w_base_neg || (w_base_cnt != LIM_POS)) begin
          w_neg_n = !w_base_neg;
        end
      end else if (w_is_ans) begin
        if (w_base_cnt == 4'd0) begin
          w_tok_n = 1'b1;
          w_neg_n = 1'b0;
        end
      end
`ifdef CALC_BACKSPACE_EN
      else if (w_is_bksp) begin
        if (w_base_tok) begin
          w_tok_n = 1'b0;
          w_neg_n = 1'b0;
        end else if (w_base_cnt != 4'd0) begin
          w_mag_n = w_base_mag / 32'd10;
          w_cnt_n = w_base_cnt - 4'd1;
        end else begin
          w_neg_n = 1'b0;
        end
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Display word, derived from the registered state so it trails any change
  // by one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fnd_n = r_fnd;
    unique case (r_state)
      S_OP1, S_OP2: begin
        if (r_ans_tok) begin
          w_fnd_n = r_neg ? DISP_NANS : DISP_ANS;
        end else if (r_neg && (r_mag == 32'd0)) begin
          w_fnd_n = DISP_NEG0;
        end else begin
          w_fnd_n = w_value;
        end
      end
      S_OPR:    w_fnd_n = {8'h00, 1'b0, r_operator, 20'h0_0000};
      S_WAIT:   w_fnd_n = r_fnd;
      S_RESULT: w_fnd_n = r_ans_reg;
      S_ERROR:  w_fnd_n = ANS_ERROR;
      default:  w_fnd_n = r_fnd;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sw_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_OP1;
      r_prev_key  <= KEY_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_key   <= KEY_IDLE;
      r_mag       <= 32'd0;
      r_cnt       <= 4'd0;
      r_neg       <= 1'b0;
      r_ans_tok   <= 1'b0;
      r_ans_reg   <= 32'd0;
      r_wait_cnt  <= 8'd0;
      r_operand1  <= 32'd0;
      r_operand2  <= 32'd0;
      r_operator  <= 3'd3;
      r_calc_go   <= 1'b0;
      r_fnd       <= 32'd0;
    end else begin
      r_prev_key  <= eBCD;
      r_evt_valid <= w_edge;
      r_evt_key   <= eBCD;
      r_state     <= w_state_n;
      r_mag       <= w_mag_n;
      r_cnt       <= w_cnt_n;
      r_neg       <= w_neg_n;
      r_ans_tok   <= w_tok_n;
      r_ans_reg   <= w_ans_reg_n;
      r_wait_cnt  <= w_wait_n;
      r_operand1  <= w_op1_n;
      r_operand2  <= w_op2_n;
      r_operator  <= w_opr_n;
      r_calc_go   <= w_go_n;
      r_fnd       <= w_fnd_n;
    end
  end

  assign operand1    = r_operand1;
  assign operand2    = r_operand2;
  assign operator    = r_operator;
  assign calc_go     = r_calc_go;
  assign fnd_serial  = r_fnd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_calc_input_fsm.sv
// -----------------------------------------------------------------------------
// tb_calc_input_fsm
//
// Directed bench for calc_input_fsm. A key-level model keeps the operand being
// typed as a list of digits and derives every output from the entry rules; a
// compare process checks the DUT against it once each press has settled, and
// literal checks pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_calc_input_fsm;

  localparam logic [4:0]  IDLE  = 5'h1F;
  localparam logic [4:0]  K_MUL = 5'h11;
  localparam logic [4:0]  K_DIV = 5'h12;
  localparam logic [4:0]  K_ADD = 5'h13;
  localparam logic [4:0]  K_SUB = 5'h14;
  localparam logic [4:0]  K_EQ  = 5'h1A;
  localparam logic [4:0]  K_ANS = 5'h1B;
  localparam logic [4:0]  K_SGN = 5'h1C;
  localparam logic [4:0]  K_BK  = 5'h1D;
  localparam logic [31:0] ERR   = 32'h00EE_0000;
  localparam int          MAXD  = 6;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  eBCD;
  logic [31:0] ans;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  operator;
  logic        calc_go;
  logic [31:0] fnd_serial;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  calc_input_fsm dut (
    .sw_clk      (clk),
    .rst         (rst),
    .eBCD        (eBCD),
    .ans         (ans),
    .operand1    (operand1),
    .operand2    (operand2),
    .operator    (operator),
    .calc_go     (calc_go),
    .fnd_serial  (fnd_serial),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int go_cycles = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every cycle calc_go is high is counted; a clean pulse is one cycle.
  always @(negedge clk) begin
    if (calc_go === 1'b1) go_cycles++;
  end

  // ---------------------------------------------------------------------------
  // Behavioural model
  // phase: 0 typing first operand, 1 operator shown, 2 typing second operand,
  //        3 showing result, 4 showing error
  // ---------------------------------------------------------------------------
  int          m_phase;
  int          m_dig[$];
  bit          m_neg;
  bit          m_tok;
  logic [31:0] m_op1;
  logic [31:0] m_op2;
  logic [2:0]  m_opr;
  logic [31:0] m_ans_reg;
  int          m_go = 0;

  task automatic m_reset();
    m_phase = 0;
    m_dig.delete();
    m_neg = 1'b0;
    m_tok = 1'b0;
    m_op1 = 32'd0;
    m_op2 = 32'd0;
    m_opr = 3'd3;
    m_ans_reg = 32'd0;
  endtask

  function automatic logic [31:0] m_mag();
    logic [31:0] v = 32'd0;
    foreach (m_dig[i]) v = v * 10 + 32'(m_dig[i]);
    return v;
  endfunction

  function automatic logic [31:0] m_value();
    logic [31:0] base = m_tok ? m_ans_reg : m_mag();
    return m_neg ? -base : base;
  endfunction

  function automatic logic [31:0] m_fnd();
    case (m_phase)
      0, 2: begin
        if (m_tok) return m_neg ? 32'hE0B0_0000 : 32'h00B0_0000;
        if (m_neg && m_dig.size() == 0) return 32'hE000_0000;
        return m_value();
      end
      1:       return {9'd0, m_opr, 20'd0};
      3:       return m_ans_reg;
      default: return ERR;
    endcase
  endfunction

  task automatic m_clear();
    m_dig.delete();
    m_neg = 1'b0;
    m_tok = 1'b0;
  endtask

  task automatic m_entry(input logic [4:0] k);
    int lim;
    if (k <= 5'h09) begin
      lim = m_neg ? MAXD - 1 : MAXD;
      if (!m_tok && m_dig.size() < lim && !(m_dig.size() == 0 && k == 5'h00))
        m_dig.push_back(int'(k));
    end else if (k == K_SGN) begin
      if (m_neg || m_dig.size() != MAXD) m_neg = !m_neg;
    end else if (k == K_ANS) begin
      if (m_dig.size() == 0) begin
        m_tok = 1'b1;
        m_neg = 1'b0;
      end
    end
`ifdef CALC_BACKSPACE_EN
    else if (k == K_BK) begin
      if (m_tok) begin
        m_tok = 1'b0;
        m_neg = 1'b0;
      end else if (m_dig.size() > 0) begin
        void'(m_dig.pop_back());
      end else begin
        m_neg = 1'b0;
      end
    end
`endif
  endtask

  task automatic model_key(input logic [4:0] k);
    bit is_opr   = (k >= 5'h11 && k <= 5'h15);
    bit is_entry = (k <= 5'h09) || k == K_ANS || k == K_SGN;
    case (m_phase)
      0: begin
        if (is_opr) begin
          m_op1 = m_value(); m_opr = k[2:0]; m_phase = 1;
        end else m_entry(k);
      end
      1: begin
        if (is_opr) m_opr = k[2:0];
        else if (is_entry) begin
          m_clear(); m_phase = 2; m_entry(k);
        end
      end
      2: begin
        if (k == K_EQ) begin
          m_op2 = m_value();
          m_go++;
          if (ans == ERR) m_phase = 4;
          else begin
            m_ans_reg = ans; m_phase = 3;
          end
        end else if (!is_opr) m_entry(k);
      end
      3: begin
        if (is_opr) begin
          m_op1 = m_ans_reg; m_opr = k[2:0]; m_phase = 1;
        end else if (is_entry) begin
          m_clear(); m_phase = 0; m_entry(k);
        end
      end
      default: begin
        if (k <= 5'h09) begin
          m_clear(); m_phase = 0; m_entry(k);
        end
      end
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: checks all outputs against the model while a press has
  // settled (2 ns after each rising edge, clear of input changes).
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (check_en) begin
        chk("fnd_serial", fnd_serial, m_fnd());
        chk("operand1", operand1, m_op1);
        chk("operand2", operand2, m_op2);
        chk("operator", {29'd0, operator}, {29'd0, m_opr});
        chk("calc_go_cycles", 32'(go_cycles), 32'(m_go));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic settle();
    repeat (7) @(negedge clk);
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    check_en = 1'b0;
  endtask

  task automatic press_h(input logic [4:0] k, input int hold);
    @(negedge clk);
    eBCD = k;
    repeat (hold) @(negedge clk);
    eBCD = IDLE;
    model_key(k);
    settle();
  endtask

  task automatic press(input logic [4:0] k);
    press_h(k, 2);
  endtask

  // Slides from k1 straight to k2 without an idle gap: only k1 counts.
  task automatic press_slide(input logic [4:0] k1, input logic [4:0] k2);
    @(negedge clk);
    eBCD = k1;
    repeat (2) @(negedge clk);
    eBCD = k2;
    repeat (2) @(negedge clk);
    eBCD = IDLE;
    model_key(k1);
    settle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    eBCD = IDLE;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst  = 1'b1;
    eBCD = IDLE;
    ans  = 32'd0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset_state", {29'd0, dbg_state}, 32'd0);
    chk("reset_fnd", fnd_serial, 32'd0);
    chk("reset_operand1", operand1, 32'd0);
    chk("reset_operator", {29'd0, operator}, 32'd3);
    chk("reset_calc_go", {31'd0, calc_go}, 32'd0);

    // 12 + 3 = 15
    ans = 32'd15;
    press(5'h01);
    press(5'h02);
    chk("t1_fnd_12", fnd_serial, 32'd12);
    press(K_ADD);
    chk("t1_fnd_add", fnd_serial, 32'h0030_0000);
    press(5'h03);
    chk("t1_fnd_3", fnd_serial, 32'd3);
    press(K_EQ);
    chk("t1_operand1", operand1, 32'd12);
    chk("t1_operand2", operand2, 32'd3);
    chk("t1_operator", {29'd0, operator}, 32'd3);
    chk("t1_go_once", 32'(go_cycles), 32'd1);
    chk("t1_fnd_15", fnd_serial, 32'd15);

    // Long hold gives one digit; unused code and key slide give nothing extra
    do_reset();
    press_h(5'h05, 10);
    chk("t2_hold_fnd", fnd_serial, 32'd5);
    press(5'h0A);
    chk("t2_unused_code", fnd_serial, 32'd5);
    do_reset();
    press_slide(5'h03, 5'h04);
    chk("t2_slide_fnd", fnd_serial, 32'd3);

    // Digit limit, positive then negative
    do_reset();
    for (int d = 1; d <= 7; d++) press(5'(d));
    chk("t3_pos_limit", fnd_serial, 32'd123456);
    press(K_SGN);
    chk("t3_sign_full", fnd_serial, 32'd123456);
    do_reset();
    press(5'h00);
    press(K_SGN);
    chk("t3_neg_zero", fnd_serial, 32'hE000_0000);
    press(5'h01); press(5'h02); press(5'h03);
    press(5'h04); press(5'h05); press(5'h06);
    chk("t3_neg_limit", fnd_serial, 32'hFFFF_CFC7);

    // Chaining from a result, ANS token display
    do_reset();
    ans = 32'd15;
    press(5'h01); press(5'h02); press(K_ADD); press(5'h03); press(K_EQ);
    ans = 32'd30;
    press(K_MUL);
    press(5'h02);
    press(K_EQ);
    chk("t4_operand1", operand1, 32'd15);
    chk("t4_operand2", operand2, 32'd2);
    chk("t4_operator", {29'd0, operator}, 32'd1);
    chk("t4_fnd_30", fnd_serial, 32'd30);
    press(K_ANS);
    chk("t4_fnd_ans", fnd_serial, 32'h00B0_0000);
    press(K_SGN);
    chk("t4_fnd_neg_ans", fnd_serial, 32'hE0B0_0000);
    press(K_ADD);
    chk("t4_operand1_neg", operand1, 32'hFFFF_FFE2);

    // Error result keeps ANS; only a digit leaves the error display
    ans = ERR;
    press(K_DIV);
    chk("t5_fnd_div", fnd_serial, 32'h0020_0000);
    press(5'h00);
    press(K_EQ);
    chk("t5_fnd_err", fnd_serial, ERR);
    press(K_ADD);
    chk("t5_err_add_fnd", fnd_serial, ERR);
    chk("t5_err_add_opr", {29'd0, operator}, 32'd2);
    press(5'h04);
    chk("t5_fnd_4", fnd_serial, 32'd4);
    ans = 32'd7;
    press(K_SUB);
    press(K_ANS);
    press(K_EQ);
    chk("t5_ans_kept", operand2, 32'd30);
    chk("t5_operand1", operand1, 32'd4);
    chk("t5_fnd_7", fnd_serial, 32'd7);

`ifdef CALC_BACKSPACE_EN
    do_reset();
    press(5'h01); press(5'h02); press(5'h03);
    press(K_BK);
    chk("t6_bksp", fnd_serial, 32'd12);
`endif

    // Reset while waiting for the result
    do_reset();
    ans = 32'd11;
    press(5'h05); press(K_ADD); press(5'h06);
    @(negedge clk);
    eBCD = K_EQ;
    @(negedge clk);
    eBCD = IDLE;
    @(negedge clk);
    m_go++;
    chk("t7_go_high", {31'd0, calc_go}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t7_go_dropped", {31'd0, calc_go}, 32'd0);
    chk("t7_fnd_zero", fnd_serial, 32'd0);
    chk("t7_state_op1", {29'd0, dbg_state}, 32'd0);
    chk("t7_operand2", operand2, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    press(5'h08);
    chk("t7_after_reset", fnd_serial, 32'd8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
